ext_mem_responder: RTL and testbench

- Memory-side end of the external load/store interface: answers load requests with forward-token data and absorbs store requests, including backward-token stall.
- Sits outside the compute fabric. Models or fronts a single-port word-addressed SRAM serving one load/store initiator.
- Serves as the bench target for load/store units and as the synthesizable external scratch memory.

---
 rtl/ext_mem_responder_pkg.sv | 40 ++++
 rtl/ext_mem_responder_sram_1p.sv | 31 +++
 rtl/ext_mem_responder.sv | 152 +++++++++++++++
 tb/tb_ext_mem_responder.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_mem_responder_pkg.sv
// Shared token types, access-mode encoding and lane-enable helper used by the
// external memory responder and the load/store units that talk to it.
package ext_mem_responder_pkg;

  localparam int TK_DATA_W = 32;
  localparam int TK_ID_W   = 4;

  typedef struct packed {
    logic                 v;
    logic                 r;
    logic                 a;
    logic                 c;
    logic [TK_ID_W-1:0]   i;
    logic [TK_DATA_W-1:0] d;
  } FTk_t;

  typedef struct packed {
    logic n;
    logic s;
  } BTk_t;

  typedef enum logic [1:0] {
    MODE_WORD     = 2'b00,
    MODE_HALF     = 2'b01,
    MODE_BYTE     = 2'b10,
    MODE_WORD_ALT = 2'b11
  } mode_e;

  // Byte lane 'lane' of an 'nbytes'-wide word takes part in an access of 'mode'.
  function automatic logic lane_en(input logic [1:0] mode, input int lane, input int nbytes);
    logic en;
    case (mode_e'(mode))
      MODE_HALF: en = (lane < nbytes / 2);
      MODE_BYTE: en = (lane == 0);
      default:   en = (lane < nbytes);
    endcase
    return en;
  endfunction

endpackage

// File: rtl/ext_mem_responder_sram_1p.sv
// Single-port word array with byte write enables and a registered read port
// (1-cycle latency); rdata holds its value until the next read.
module ext_mem_sram_1p #(
  parameter int WIDTH_DATA = 32,
  parameter int DEPTH      = 1024,
  parameter int AW         = 10
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic                    we,
  input  logic [WIDTH_DATA/8-1:0] be,
  input  logic [AW-1:0]           addr,
  input  logic [WIDTH_DATA-1:0]   wdata,
  output logic [WIDTH_DATA-1:0]   rdata
);

  logic [WIDTH_DATA-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < WIDTH_DATA / 8; b++) begin
          if (be[b]) mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/ext_mem_responder.sv
// Memory-side responder for the external load/store interface; loads win the single port.
// Load data one cycle after grant with a one-entry skid; EXT_MEM_RANGE_CHK_EN adds range checking.
module ext_mem_responder
  import ext_mem_responder_pkg::*;
#(
  parameter int WIDTH_DATA = 32,
  parameter int WIDTH_ADDR = 10,
  parameter int DEPTH      = 1024
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  I_Ld_Req,
  input  logic [1:0]            I_Ld_Mode,
  input  logic [WIDTH_ADDR-1:0] I_Ld_Address,
  output FTk_t                  O_Ld_Data,
  input  BTk_t                  I_Ld_BTk,
  input  logic                  I_St_Req,
  input  logic [1:0]            I_St_Mode,
  input  logic [WIDTH_ADDR-1:0] I_St_Address,
  input  FTk_t                  I_St_Data,
  output BTk_t                  O_St_BTk,
  output logic                  O_St_End,
  output logic [1:0]            O_Err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NB = WIDTH_DATA / 8;

  logic                  active;
  logic                  held_vld;
  logic                  fresh_vld;
  logic [WIDTH_DATA-1:0] held_d;
  logic [1:0]            rd_mode_q;
  logic                  rd_oor_q;
  logic                  st_end_q;
  logic                  err_drop;
  logic                  err_oor;

  logic                  skid_full;
  logic                  ld_go;
  logic                  st_vld;
  logic                  st_go;
  logic                  ld_oor;
  logic                  st_oor;
  logic                  sram_en;
  logic                  sram_we;
  logic [NB-1:0]         st_be;
  logic [AW-1:0]         sram_addr;
  logic [WIDTH_DATA-1:0] rdata;
  logic [WIDTH_DATA-1:0] rd_mask;
  logic [WIDTH_DATA-1:0] fresh_d;
  logic                  unused;

  // Output slot is held_d when a stalled word was captured, else the SRAM read
  // register; a second word parked in the read register is the skid entry.
  assign skid_full = held_vld & fresh_vld;
  assign ld_go     = active & I_Ld_Req & ~skid_full;
  assign st_vld    = active & I_St_Req & I_St_Data.v;
  assign st_go     = st_vld & ~ld_go;

  always_comb begin
    O_St_BTk   = '0;
    O_St_BTk.n = st_vld & ld_go;
  end

`ifdef EXT_MEM_RANGE_CHK_EN
  assign ld_oor = 32'(I_Ld_Address) >= 32'(DEPTH);
  assign st_oor = 32'(I_St_Address) >= 32'(DEPTH);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_oor <= 1'b0;
    end else if ((ld_go & ld_oor) | (st_go & st_oor)) begin
      err_oor <= 1'b1;
    end
  end
`else
  assign ld_oor  = 1'b0;
  assign st_oor  = 1'b0;
  assign err_oor = 1'b0;
`endif

  assign sram_we   = st_go & ~st_oor;
  assign sram_en   = ld_go | sram_we;
  assign sram_addr = ld_go ? I_Ld_Address[AW-1:0] : I_St_Address[AW-1:0];

  always_comb begin
    st_be   = '0;
    rd_mask = '0;
    for (int b = 0; b < NB; b++) begin
      st_be[b]          = lane_en(I_St_Mode, b, NB);
      rd_mask[b*8 +: 8] = {8{lane_en(rd_mode_q, b, NB)}};
    end
  end

  assign fresh_d = rd_oor_q ? '0 : (rdata & rd_mask);

  ext_mem_sram_1p #(
    .WIDTH_DATA (WIDTH_DATA),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_sram (
    .clk   (clock),
    .en    (sram_en),
    .we    (sram_we),
    .be    (st_be),
    .addr  (sram_addr),
    .wdata (I_St_Data.d[WIDTH_DATA-1:0]),
    .rdata (rdata)
  );

  always_comb begin
    O_Ld_Data = '0;
    if (held_vld) begin
      O_Ld_Data.v = 1'b1;
      O_Ld_Data.d = TK_DATA_W'(held_d);
    end else if (fresh_vld) begin
      O_Ld_Data.v = 1'b1;
      O_Ld_Data.d = TK_DATA_W'(fresh_d);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      active    <= 1'b0;
      held_vld  <= 1'b0;
      fresh_vld <= 1'b0;
      held_d    <= '0;
      rd_mode_q <= '0;
      rd_oor_q  <= 1'b0;
      st_end_q  <= 1'b0;
      err_drop  <= 1'b0;
    end else begin
      active    <= 1'b1;
      fresh_vld <= ld_go | skid_full;
      held_vld  <= held_vld ? I_Ld_BTk.n : (fresh_vld & I_Ld_BTk.n);
      if (!held_vld && fresh_vld && I_Ld_BTk.n) held_d <= fresh_d;
      if (ld_go) begin
        rd_mode_q <= I_Ld_Mode;
        rd_oor_q  <= ld_oor;
      end
      st_end_q <= st_go & I_St_Data.r;
      if (I_Ld_Req && skid_full) err_drop <= 1'b1;
    end
  end

  assign O_St_End = st_end_q;
  assign O_Err    = {err_drop, err_oor};

  assign unused = ^{I_Ld_BTk.s, I_St_Data.i, I_St_Data.a, I_St_Data.c};

endmodule

// File: tb/tb_ext_mem_responder.sv
// Directed bench for ext_mem_responder with a load scoreboard and a reference word model.
module tb_ext_mem_responder;
  import ext_mem_responder_pkg::*;

  localparam int WD = 32;
  localparam int WA = 11;
  localparam int DP = 1024;
`ifdef EXT_MEM_RANGE_CHK_EN
  localparam logic OOR_EXP = 1'b1;
`else
  localparam logic OOR_EXP = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          I_Ld_Req;
  logic [1:0]    I_Ld_Mode;
  logic [WA-1:0] I_Ld_Address;
  FTk_t          O_Ld_Data;
  BTk_t          I_Ld_BTk;
  logic          I_St_Req;
  logic [1:0]    I_St_Mode;
  logic [WA-1:0] I_St_Address;
  FTk_t          I_St_Data;
  BTk_t          O_St_BTk;
  logic          O_St_End;
  logic [1:0]    O_Err;

  always #5 clock = ~clock;

  ext_mem_responder #(.WIDTH_DATA(WD), .WIDTH_ADDR(WA), .DEPTH(DP)) dut (
    .clock        (clock),
    .reset        (reset),
    .I_Ld_Req     (I_Ld_Req),
    .I_Ld_Mode    (I_Ld_Mode),
    .I_Ld_Address (I_Ld_Address),
    .O_Ld_Data    (O_Ld_Data),
    .I_Ld_BTk     (I_Ld_BTk),
    .I_St_Req     (I_St_Req),
    .I_St_Mode    (I_St_Mode),
    .I_St_Address (I_St_Address),
    .I_St_Data    (I_St_Data),
    .O_St_BTk     (O_St_BTk),
    .O_St_End     (O_St_End),
    .O_Err        (O_Err)
  );

  int          checks = 0;
  int          errors = 0;
  int          ld_seen = 0;
  FTk_t        exp_q[$];
  logic [31:0] model [DP];
  FTk_t        ld_s;
  BTk_t        st_btk_s;
  logic        st_end_s;
  logic [1:0]  err_s;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [1:0] m);
    case (m)
      2'b01:   return {o[31:16], n[15:0]};
      2'b10:   return {o[31:8], n[7:0]};
      default: return n;
    endcase
  endfunction

  function automatic logic [31:0] lmask(input logic [31:0] w, input logic [1:0] m);
    case (m)
      2'b01:   return w & 32'h0000_FFFF;
      2'b10:   return w & 32'h0000_00FF;
      default: return w;
    endcase
  endfunction

  function automatic FTk_t exp_ld(input logic [WA-1:0] a, input logic [1:0] m);
    FTk_t e;
    e   = '0;
    e.v = 1'b1;
    e.d = lmask(model[a[9:0]], m);
`ifdef EXT_MEM_RANGE_CHK_EN
    if (a >= WA'(DP)) e.d = '0;
`endif
    return e;
  endfunction

  task automatic store_model(input logic [WA-1:0] a, input logic [31:0] d, input logic [1:0] m);
`ifdef EXT_MEM_RANGE_CHK_EN
    if (a < WA'(DP)) model[a[9:0]] = merge(model[a[9:0]], d, m);
`else
    model[a[9:0]] = merge(model[a[9:0]], d, m);
`endif
  endtask

  // One clock: sample outputs at the falling edge, score accepted loads, return after the rising edge.
  task automatic tick();
    @(negedge clock);
    ld_s     = O_Ld_Data;
    st_btk_s = O_St_BTk;
    st_end_s = O_St_End;
    err_s    = O_Err;
    if (O_Ld_Data.v && !I_Ld_BTk.n) begin
      ld_seen++;
      if (exp_q.size() == 0) check("ld_unexpected_v", 64'(O_Ld_Data.v), 64'd0);
      else check("ld_data", 64'(O_Ld_Data), 64'(exp_q.pop_front()));
    end
    @(posedge clock);
    #1;
  endtask

  task automatic drive_store(input logic [WA-1:0] a, input logic [31:0] d, input logic [1:0] m, input logic last);
    I_St_Req       = 1'b1;
    I_St_Mode      = m;
    I_St_Address   = a;
    I_St_Data      = '0;
    I_St_Data.v    = 1'b1;
    I_St_Data.r    = last;
    I_St_Data.d    = d;
  endtask

  task automatic idle_store();
    I_St_Req  = 1'b0;
    I_St_Data = '0;
  endtask

  task automatic do_store(input logic [WA-1:0] a, input logic [31:0] d, input logic [1:0] m);
    drive_store(a, d, m, 1'b0);
    tick();
    check("st_no_stall", 64'(st_btk_s.n), 64'd0);
    store_model(a, d, m);
    idle_store();
  endtask

  task automatic do_load(input logic [WA-1:0] a, input logic [1:0] m);
    I_Ld_Req     = 1'b1;
    I_Ld_Mode    = m;
    I_Ld_Address = a;
    exp_q.push_back(exp_ld(a, m));
    tick();
    I_Ld_Req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int   issued;
    int   seen0;
    logic prev_n;

    I_Ld_Req = 0; I_Ld_Mode = 0; I_Ld_Address = 0; I_Ld_BTk = '0;
    I_St_Req = 0; I_St_Mode = 0; I_St_Address = 0; I_St_Data = '0;
    for (int k = 0; k < DP; k++) model[k] = '0;

    #12;
    check("rst_ld_data", 64'(O_Ld_Data), 64'd0);
    check("rst_st_btk", 64'(O_St_BTk), 64'd0);
    check("rst_st_end", 64'(O_St_End), 64'd0);
    check("rst_err", 64'(O_Err), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    tick();

    // word store then immediate load: data one cycle after grant
    do_store(11'd5, 32'hDEAD_BEEF, 2'b00);
    do_load(11'd5, 2'b00);
    check("ld_lat_early_v", 64'(ld_s.v), 64'd0);
    tick();
    check("ld_lat_v", 64'(ld_s.v), 64'd1);

    // byte store over existing word, then word and half loads
    do_store(11'd5, 32'h0000_00AA, 2'b10);
    do_load(11'd5, 2'b00);
    do_load(11'd5, 2'b01);
    tick(); tick();
    check("byte_merge_model", 64'(model[5]), 64'hDEAD_BEAA);

    // four-word store burst, last flagged
    for (int i = 0; i < 4; i++) begin
      drive_store(WA'(i), 32'hA000_0000 + 32'(i) * 32'h0101_0101, 2'b00, i == 3);
      tick();
      check("st_end_burst", 64'(st_end_s), 64'd0);
      store_model(WA'(i), 32'hA000_0000 + 32'(i) * 32'h0101_0101, 2'b00);
    end
    idle_store();
    tick();
    check("st_end_pulse", 64'(st_end_s), 64'd1);
    tick();
    check("st_end_clear", 64'(st_end_s), 64'd0);

    // load stream 0..3 with a three-cycle stall after word 1
    issued = 0;
    prev_n = 1'b0;
    seen0  = ld_seen;
    for (int c = 0; c < 30 && (ld_seen - seen0) < 4; c++) begin
      I_Ld_BTk.n = (c >= 2 && c <= 4);
      if (issued < 4 && !prev_n) begin
        I_Ld_Req     = 1'b1;
        I_Ld_Mode    = 2'b00;
        I_Ld_Address = WA'(issued);
        exp_q.push_back(exp_ld(WA'(issued), 2'b00));
        issued++;
      end else begin
        I_Ld_Req = 1'b0;
      end
      tick();
      if (c == 3) check("stall_hold_d", 64'(ld_s.d), 64'(model[1]));
      prev_n = I_Ld_BTk.n;
    end
    I_Ld_Req   = 1'b0;
    I_Ld_BTk.n = 1'b0;
    check("stall_words", 64'(ld_seen - seen0), 64'd4);
    check("stall_err1", 64'(err_s[1]), 64'd0);

    // simultaneous load and store: store stalled exactly one cycle
    I_Ld_Req = 1'b1; I_Ld_Mode = 2'b00; I_Ld_Address = 11'd0;
    exp_q.push_back(exp_ld(11'd0, 2'b00));
    drive_store(11'd9, 32'h1234_5678, 2'b00, 1'b0);
    tick();
    check("ldst_btk_first", 64'(st_btk_s.n), 64'd1);
    I_Ld_Req = 1'b0;
    tick();
    check("ldst_btk_second", 64'(st_btk_s.n), 64'd0);
    store_model(11'd9, 32'h1234_5678, 2'b00);
    idle_store();
    do_load(11'd9, 2'b00);
    tick(); tick();

    // out-of-range store: suppressed with the range check, aliased without
    do_store(11'd76, 32'h7676_7676, 2'b00);
    do_store(11'd1100, 32'hCAFE_F00D, 2'b00);
    tick();
    check("err_oor", 64'(err_s[0]), 64'(OOR_EXP));
    do_load(11'd76, 2'b00);
    do_load(11'd1100, 2'b00);
    tick(); tick();

    // contract violation: request while the skid is full is dropped
    seen0 = ld_seen;
    I_Ld_Mode = 2'b00;
    I_Ld_Req = 1'b1; I_Ld_Address = 11'd2; exp_q.push_back(exp_ld(11'd2, 2'b00));
    tick();
    I_Ld_BTk.n = 1'b1; I_Ld_Address = 11'd3; exp_q.push_back(exp_ld(11'd3, 2'b00));
    tick();
    I_Ld_Address = 11'd0;
    tick();
    I_Ld_Req = 1'b0; I_Ld_BTk.n = 1'b0;
    tick();
    check("drop_err1", 64'(err_s[1]), 64'd1);
    tick(); tick(); tick();
    check("drop_count", 64'(ld_seen - seen0), 64'd2);

    // reset asserted mid-stream with load and store both requesting
    I_Ld_Req = 1'b1; I_Ld_Address = 11'd1; exp_q.push_back(exp_ld(11'd1, 2'b00));
    tick();
    drive_store(11'd20, 32'h5555_AAAA, 2'b00, 1'b1);
    #1;
    check("pre_rst_btk", 64'(O_St_BTk.n), 64'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_ld_data", 64'(O_Ld_Data), 64'd0);
    check("mid_rst_st_btk", 64'(O_St_BTk), 64'd0);
    check("mid_rst_st_end", 64'(O_St_End), 64'd0);
    check("mid_rst_err", 64'(O_Err), 64'd0);
    exp_q.delete();
    I_Ld_Req = 1'b0;
    idle_store();
    tick();
    reset = 1'b1;
    tick(); tick();
    check("post_rst_ld_v", 64'(ld_s.v), 64'd0);
    check("post_rst_err", 64'(err_s), 64'd0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
